row_max_sequencer: RTL
======================

ROW_MAX_SEQUENCER -- requirements
Module: row_max_sequencer

Interface
REQ-001 Parameter N, default 8, lanes per chunk; power of two, 2..64.
REQ-002 Parameter MAX_CHUNKS, default 64, largest row length in chunks.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin a row; honoured only in IDLE.
REQ-006 len_chunks  in  $clog2(MAX_CHUNKS+1)  row length in chunks; sampled with start.
REQ-007 chunk_valid  in  1  chunk offered.
REQ-008 chunk_ready  out  1  sequencer accepts chunk this cycle.
REQ-009 chunk_data  in  N*16  N signed Q6.10 lanes; lane i at bits [i*16 +: 16].
REQ-010 chunk_mask  in  N  1 = lane live, 0 = lane padding.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 max_valid  out  1  row maximum available.
REQ-013 max_ready  in  1  consumer takes row maximum.
REQ-014 max_out  out  16  signed row maximum.

Function
REQ-015 States: IDLE, FEED, DRAIN, DONE, in a 2-bit encoded register.
REQ-016 IDLE: start with len_chunks>0 latches the length, clears both counters and goes to FEED.
REQ-017 IDLE: start with len_chunks=0 goes directly to DONE with max_out=16'h8000.
REQ-018 Length rule: len_chunks>MAX_CHUNKS is clamped to MAX_CHUNKS.
REQ-019 chunk_ready is high only in FEED and only while issued<len.
REQ-020 Handshake occurs when chunk_valid&chunk_ready are high at a rising edge.
- Each handshake increments the issued count and presents the chunk to the tree with all N valid bits high.
- Non-handshake cycles present valid bits all zero.
REQ-021 Masked lanes (chunk_mask[i]=0) are replaced by 16'h8000 before the tree.
- A fully masked chunk contributes -32768.
REQ-022 FEED moves to DRAIN on the edge of the handshake that makes issued==len.
REQ-023 Tree enable is tied high whenever rst is low; the tree never stalls.
REQ-024 Each valid tree output increments the received count and updates the accumulator.
- First result of a row loads the accumulator.
- Later results store max(acc, result), signed compare; on equality acc is kept.
REQ-025 DRAIN moves to DONE on the edge at which the accumulator takes the result making received==len.
REQ-026 Latency: last handshake at edge E gives max_valid high from edge E+log2(N) (E+3 for N=8).
REQ-027 DONE: max_valid=1 and max_out holds stable until max_ready=1; that edge returns to IDLE.
REQ-028 start in DONE is ignored; start on the same edge as the DONE->IDLE transition is also ignored.
REQ-029 chunk_valid outside FEED is ignored; no data is consumed.
REQ-030 Back-to-back rows: a new start is accepted the cycle after IDLE is re-entered.
REQ-031 Counters are $clog2(MAX_CHUNKS+1) bits wide and never wrap, since issued≤len≤MAX_CHUNKS.

Reset
REQ-032 rst at any edge, mid-row included, forces the following:
- state=IDLE; counters and accumulator=0;
- chunk_ready=0, busy=0, max_valid=0, max_out=16'h0000;
- tree pipeline registers cleared; in-flight results are discarded.
REQ-033 rst has priority over every other input in the same cycle.

Structure
REQ-034 Shared package holds:
- state enum;
- Q6.10 width constant (16);
- NEG_MAX constant 16'h8000.
REQ-035 Sub-module: one instance of the existing max_tree with parameter N.
- Bypass outputs of the instance are left unconnected.
REQ-036 Lane masking, counters, FSM and accumulator live in row_max_sequencer.

Verification
REQ-037 Single row, N=8:
- Stimulus: start, len=1; lanes {5,-3,100,7,0,-1,2,99} all live.
- Response: max_out=100, max_valid high at E+3.
REQ-038 Three chunks, chunk_valid gapped one cycle between chunks; chunk maxima 10, 250, -4.
- Response: max_out=250.
- chunk_ready never high after the third handshake.
REQ-039 All-negative row with mask=8'b00000001, lane0=-20, others 300.
- Response: max_out=-20.
REQ-040 len=0:
- Response: DONE next edge with max_out=16'h8000.
- max_ready held low for 5 cycles: max_valid and max_out stay stable; max_ready=1 returns busy=0.
REQ-041 rst asserted mid-DRAIN of a len=4 row, then a new len=1 row with max 42.
- Response: max_out=42; no stale value from the aborted row.
REQ-042 start pulsed during FEED and during DONE:
- Response: no effect on length, counters or max_out.

Source files
------------

// File: rtl/row_max_sequencer_pkg.sv
// Shared types and constants for the row maximum sequencer and its reduction tree.
// Q6.10 lanes are 16-bit signed; NEG_MAX is the most negative value, used as padding.
package row_max_sequencer_pkg;

    localparam int unsigned Q_WIDTH = 16;
    localparam logic [Q_WIDTH-1:0] NEG_MAX = 16'h8000;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } state_e;

    // Signed maximum; on equality the first operand wins.
    function automatic logic [Q_WIDTH-1:0] smax(input logic [Q_WIDTH-1:0] a,
                                                input logic [Q_WIDTH-1:0] b);
        return ($signed(b) > $signed(a)) ? b : a;
    endfunction

endpackage

// File: rtl/max_tree.sv
// Pipelined signed max reduction over N lanes, one register level per tree level.
// Result appears log2(N) cycles after a valid input; invalid lanes count as NEG_MAX.
module max_tree
    import row_max_sequencer_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N-1:0]           in_valid,
    input  logic [N*Q_WIDTH-1:0]   in_data,
    output logic                   out_valid,
    output logic [Q_WIDTH-1:0]     out_max,
    output logic [N*Q_WIDTH-1:0]   bypass_data
);

    localparam int unsigned Levels = $clog2(N);

    // Heap layout: node k has children 2k and 2k+1; leaves occupy N..2N-1.
    logic [Q_WIDTH-1:0] node_q [1:N-1];
    logic [Q_WIDTH-1:0] node   [2:2*N-1];
    logic [Levels-1:0]  vld_q;

    always_comb begin
        bypass_data = '0;
        for (int unsigned k = 2; k < N; k++) begin
            node[k] = node_q[k];
        end
        for (int unsigned i = 0; i < N; i++) begin
            node[N+i] = in_valid[i] ? in_data[i*Q_WIDTH +: Q_WIDTH] : NEG_MAX;
            bypass_data[i*Q_WIDTH +: Q_WIDTH] = node[N+i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned k = 1; k < N; k++) begin
                node_q[k] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= |in_valid;
            for (int unsigned l = 1; l < Levels; l++) begin
                vld_q[l] <= vld_q[l-1];
            end
            for (int unsigned k = 1; k < N; k++) begin
                node_q[k] <= smax(node[2*k], node[2*k+1]);
            end
        end
    end

    assign out_valid = vld_q[Levels-1];
    assign out_max   = node_q[1];

endmodule

// File: rtl/row_max_sequencer.sv
// Streams a row of N-lane Q6.10 chunks through a pipelined max tree and reports
// the signed row maximum once every in-flight tree result has been folded in.
module row_max_sequencer
    import row_max_sequencer_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned MAX_CHUNKS = 64,
    localparam int unsigned CW        = $clog2(MAX_CHUNKS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CW-1:0]        len_chunks,
    input  logic                 chunk_valid,
    output logic                 chunk_ready,
    input  logic [N*Q_WIDTH-1:0] chunk_data,
    input  logic [N-1:0]         chunk_mask,
    output logic                 busy,
    output logic                 max_valid,
    input  logic                 max_ready,
    output logic [Q_WIDTH-1:0]   max_out
);

    localparam logic [CW-1:0] MaxLen = CW'(MAX_CHUNKS);

    state_e               state_q, state_d;
    logic [CW-1:0]        len_q, issued_q, received_q, len_clamp;
    logic [Q_WIDTH-1:0]   acc_q;
    logic                 hs, last_issue, last_result, tree_en;
    logic [N-1:0]         tree_valid;
    logic [N*Q_WIDTH-1:0] tree_data;
    logic                 res_valid;
    logic [Q_WIDTH-1:0]   res_max;

    assign len_clamp   = (len_chunks > MaxLen) ? MaxLen : len_chunks;
    assign hs          = chunk_valid & chunk_ready;
    assign last_issue  = hs && (issued_q + CW'(1) == len_q);
    assign last_result = res_valid && (received_q + CW'(1) == len_q);
    assign tree_en     = ~rst;
    assign tree_valid  = {N{hs}};

    always_comb begin
        tree_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            tree_data[i*Q_WIDTH +: Q_WIDTH] =
                chunk_mask[i] ? chunk_data[i*Q_WIDTH +: Q_WIDTH] : NEG_MAX;
        end
    end

    max_tree #(
        .N (N)
    ) u_max_tree (
        .clk         (clk),
        .rst         (rst),
        .en          (tree_en),
        .in_valid    (tree_valid),
        .in_data     (tree_data),
        .out_valid   (res_valid),
        .out_max     (res_max),
        .bypass_data ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (len_clamp == '0) ? StDone : StFeed;
            StFeed:  if (last_issue) state_d = StDrain;
            StDrain: if (last_result) state_d = StDone;
            StDone:  if (max_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        chunk_ready = (state_q == StFeed) && (issued_q < len_q);
        busy        = (state_q != StIdle);
        max_valid   = (state_q == StDone);
        max_out     = acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            acc_q      <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                len_q      <= len_clamp;
                issued_q   <= '0;
                received_q <= '0;
                if (len_clamp == '0) acc_q <= NEG_MAX;
            end
            if (hs) issued_q <= issued_q + CW'(1);
            // The first result of a row loads; later ones keep the running signed max.
            if (res_valid) begin
                received_q <= received_q + CW'(1);
                acc_q      <= (received_q == '0) ? res_max : smax(acc_q, res_max);
            end
        end
    end

endmodule
